// File: rtl/hwpe_multi_stream_fsm_if.sv
// Handshake bundle between the HWPE control FSM and its streamers, engine and uloop.
// The master side is the FSM; the slave side is the datapath it sequences.
interface hwpe_multi_stream_fsm_if #(
  parameter int unsigned N_SRC  = 2,
  parameter int unsigned N_SINK = 1,
  parameter int unsigned CNT_W  = 32
);
  logic [N_SRC-1:0]        src_ready_start;
  logic [N_SINK-1:0]       sink_ready_start;
  logic [N_SRC-1:0]        src_req_start;
  logic [N_SINK-1:0]       sink_req_start;
  logic [N_SINK*CNT_W-1:0] cnt_out;
  logic                    eng_ready;
  logic                    eng_start;
  logic                    eng_clear;
  logic                    eng_enable;
  logic                    ucode_valid;
  logic                    ucode_done;
  logic                    ucode_enable;
  logic                    ucode_clear;

  modport master (
    input  src_ready_start, sink_ready_start, cnt_out, eng_ready, ucode_valid, ucode_done,
    output src_req_start, sink_req_start, eng_start, eng_clear, eng_enable, ucode_enable, ucode_clear
  );

  modport slave (
    output src_ready_start, sink_ready_start, cnt_out, eng_ready, ucode_valid, ucode_done,
    input  src_req_start, sink_req_start, eng_start, eng_clear, eng_enable, ucode_enable, ucode_clear
  );
endinterface

// File: rtl/hwpe_multi_stream_fsm.sv
// HWPE control FSM for multiple masked source/sink streams: launches tiles, tracks per-sink completion,
// steps the uloop between tiles and aborts stuck jobs through a stall watchdog.
module hwpe_multi_stream_fsm #(
  parameter int unsigned N_SRC  = 2,
  parameter int unsigned N_SINK = 1,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned TMO_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    start_i,
  input  logic [N_SRC-1:0]        src_mask_i,
  input  logic [N_SINK-1:0]       sink_mask_i,
  input  logic [N_SINK*CNT_W-1:0] cnt_limit_i,
  input  logic [TMO_W-1:0]        tmo_limit_i,
  hwpe_multi_stream_fsm_if.master ctrl,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    busy_o,
  output logic [2:0]              state_o
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    COMPUTE   = 3'd2,
    UPDATEIDX = 3'd3,
    WAIT      = 3'd4,
    TERMINATE = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [TMO_W-1:0]  wd_cnt_q, wd_cnt_d;
  logic              src_rdy, sink_rdy, rdy_all, fin_all, empty_job;
  logic              wd_stuck, wd_expired, launch;
  logic [N_SINK-1:0] sink_fin;
  logic [N_SRC-1:0]  src_req;
  logic [N_SINK-1:0] sink_req;
  logic              eng_start, eng_clear, eng_enable, ucode_enable, ucode_clear, done, err;

  function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Masked streams count as ready and masked sinks count as finished.
  assign src_rdy   = &(ctrl.src_ready_start | ~src_mask_i);
  assign sink_rdy  = &(ctrl.sink_ready_start | ~sink_mask_i);
  assign rdy_all   = src_rdy & sink_rdy;
  assign empty_job = ~(|src_mask_i) & ~(|sink_mask_i);

  always_comb begin
    for (int k = 0; k < N_SINK; k++) begin
      sink_fin[k] = ~sink_mask_i[k] |
                    (ctrl.cnt_out[k*CNT_W +: CNT_W] >= cnt_limit_i[k*CNT_W +: CNT_W]);
    end
  end
  assign fin_all = &sink_fin;

  assign wd_stuck   = (state_q == WAIT) || (state_q == TERMINATE);
  assign wd_expired = wd_stuck && (tmo_limit_i != '0) && (wd_cnt_q >= tmo_limit_i);
  assign wd_cnt_d   = (wd_stuck && (state_d == state_q)) ? sat_inc(wd_cnt_q) : '0;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      wd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      wd_cnt_q <= wd_cnt_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    launch       = 1'b0;
    src_req      = '0;
    sink_req     = '0;
    eng_start    = 1'b0;
    eng_clear    = 1'b0;
    eng_enable   = 1'b0;
    ucode_enable = 1'b0;
    ucode_clear  = 1'b0;
    done         = 1'b0;
    err          = 1'b0;
    case (state_q)
      IDLE: begin
        eng_clear   = 1'b1;
        ucode_clear = 1'b1;
        if (start_i) state_d = empty_job ? TERMINATE : START;
      end
      START: begin
        if (rdy_all) launch = 1'b1;
        else         state_d = WAIT;
      end
      COMPUTE: begin
        eng_enable = 1'b1;
        eng_start  = ctrl.eng_ready;
        if (fin_all) state_d = UPDATEIDX;
      end
      UPDATEIDX: begin
        // Counters are cleared while the uloop computes the next tile's offsets.
        eng_clear = 1'b1;
        if (!ctrl.ucode_valid)    ucode_enable = 1'b1;
        else if (ctrl.ucode_done) state_d = TERMINATE;
        else if (rdy_all)         launch = 1'b1;
        else                      state_d = WAIT;
      end
      WAIT: begin
        if (rdy_all) launch = 1'b1;
        else if (wd_expired) begin
          err     = 1'b1;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      TERMINATE: begin
        if (rdy_all || wd_expired) begin
          err     = ~rdy_all;
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      eng_start  = 1'b1;
      eng_enable = 1'b1;
      eng_clear  = 1'b0;
      src_req    = src_mask_i;
      sink_req   = sink_mask_i;
      state_d    = COMPUTE;
    end

    // A soft clear wins over every transition and suppresses the pulses it would have produced.
    if (clear_i) begin
      state_d      = IDLE;
      src_req      = '0;
      sink_req     = '0;
      eng_start    = 1'b0;
      ucode_enable = 1'b0;
      done         = 1'b0;
      err          = 1'b0;
    end
  end

  assign ctrl.src_req_start  = src_req;
  assign ctrl.sink_req_start = sink_req;
  assign ctrl.eng_start      = eng_start;
  assign ctrl.eng_clear      = eng_clear;
  assign ctrl.eng_enable     = eng_enable;
  assign ctrl.ucode_enable   = ucode_enable;
  assign ctrl.ucode_clear    = ucode_clear;
  assign done_o              = done;
  assign err_o               = err;
  assign busy_o              = (state_q != IDLE);
  assign state_o             = state_q;

endmodule

// File: tb/tb_hwpe_multi_stream_fsm.sv
// Bench for hwpe_multi_stream_fsm: directed job scenarios plus randomized jobs, each cycle compared
// with a reference model of the job phases, alongside stub streamers, engine counters and uloop.
`timescale 1ns/1ps
module tb_hwpe_multi_stream_fsm;
  localparam int N_SRC = 2, N_SINK = 2, CNT_W = 8, TMO_W = 4;

  logic                    clk = 1'b0;
  logic                    rst_ni, clear_i, start_i;
  logic [N_SRC-1:0]        src_mask;
  logic [N_SINK-1:0]       sink_mask;
  logic [N_SINK*CNT_W-1:0] cnt_limit;
  logic [TMO_W-1:0]        tmo_limit;
  logic                    done_o, err_o, busy_o;
  logic [2:0]              state_o;

  always #5 clk = ~clk;

  hwpe_multi_stream_fsm_if #(.N_SRC(N_SRC), .N_SINK(N_SINK), .CNT_W(CNT_W)) bus ();

  hwpe_multi_stream_fsm #(.N_SRC(N_SRC), .N_SINK(N_SINK), .CNT_W(CNT_W), .TMO_W(TMO_W)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .clear_i(clear_i), .start_i(start_i),
    .src_mask_i(src_mask), .sink_mask_i(sink_mask), .cnt_limit_i(cnt_limit),
    .tmo_limit_i(tmo_limit), .ctrl(bus), .done_o(done_o), .err_o(err_o),
    .busy_o(busy_o), .state_o(state_o)
  );

  int n_assert = 0, n_fail = 0;
  // Reference model: job phase (0 idle,1 start,2 compute,3 update,4 wait,5 terminate) and stall cycles.
  int m_state = 0, m_wd = 0;
  // Environment stubs
  logic [CNT_W-1:0]  env_cnt [N_SINK];
  int                env_iter = 0, env_tiles = 1, rdy_pct = 70;
  bit                env_need_step = 0, cnt_auto = 0, rdy_rand = 0;
  logic [N_SRC-1:0]  src_rdy_fix = '0;
  logic [N_SINK-1:0] sink_rdy_fix = '0;
  // Last sampled DUT outputs and job scoreboard
  logic [N_SRC-1:0]  o_src;
  logic [N_SINK-1:0] o_sink;
  logic              o_es, o_ec, o_ee, o_ue, o_uc, o_done, o_err, o_busy;
  logic [2:0]        o_state;
  bit                prev_pulse = 0;
  int                launches = 0, dones = 0, errs = 0, ue_pulses = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clr_sb();
    launches = 0; dones = 0; errs = 0; ue_pulses = 0;
  endtask

  // One clock cycle: drive stubs at the negedge, check outputs, then advance model at the posedge.
  task automatic step();
    logic [N_SRC-1:0]  rs, e_src;
    logic [N_SINK-1:0] rk, e_sink;
    logic er, uv, ud, e_es, e_ec, e_ee, e_ue, e_uc, e_done, e_err;
    bit   rdy, fin, launch, stuck, expired;
    int   nxt;
    for (int i = 0; i < N_SRC; i++)  rs[i] = rdy_rand ? ($urandom_range(99) < rdy_pct) : src_rdy_fix[i];
    for (int k = 0; k < N_SINK; k++) rk[k] = rdy_rand ? ($urandom_range(99) < rdy_pct) : sink_rdy_fix[k];
    er = 1'($urandom_range(1));
    uv = !env_need_step;
    ud = (env_iter >= env_tiles);
    bus.src_ready_start = rs; bus.sink_ready_start = rk; bus.eng_ready = er;
    bus.ucode_valid = uv; bus.ucode_done = ud;
    for (int k = 0; k < N_SINK; k++) bus.cnt_out[k*CNT_W +: CNT_W] = env_cnt[k];
    #1;
    rdy = 1;
    for (int i = 0; i < N_SRC; i++)  if (src_mask[i] && !rs[i]) rdy = 0;
    for (int k = 0; k < N_SINK; k++) if (sink_mask[k] && !rk[k]) rdy = 0;
    fin = 1;
    for (int k = 0; k < N_SINK; k++) if (sink_mask[k] && env_cnt[k] < cnt_limit[k*CNT_W +: CNT_W]) fin = 0;
    stuck   = (m_state == 4 || m_state == 5);
    expired = stuck && (tmo_limit != 0) && (m_wd >= int'(tmo_limit));
    e_src = '0; e_sink = '0; e_es = 0; e_ec = 0; e_ee = 0; e_ue = 0; e_uc = 0; e_done = 0; e_err = 0;
    nxt = m_state; launch = 0;
    case (m_state)
      0: begin e_ec = 1; e_uc = 1; if (start_i) nxt = (src_mask == 0 && sink_mask == 0) ? 5 : 1; end
      1: if (rdy) launch = 1; else nxt = 4;
      2: begin e_ee = 1; e_es = er; if (fin) nxt = 3; end
      3: begin
        e_ec = 1;
        if (!uv) e_ue = 1; else if (ud) nxt = 5; else if (rdy) launch = 1; else nxt = 4;
      end
      4: if (rdy) launch = 1; else if (expired) begin e_err = 1; e_done = 1; nxt = 0; end
      5: if (rdy) begin e_done = 1; nxt = 0; end else if (expired) begin e_err = 1; e_done = 1; nxt = 0; end
      default: nxt = 0;
    endcase
    if (launch) begin e_es = 1; e_ee = 1; e_ec = 0; e_src = src_mask; e_sink = sink_mask; nxt = 2; end
    if (clear_i) begin
      nxt = 0; launch = 0; e_done = 0; e_err = 0; e_src = '0; e_sink = '0; e_es = 0; e_ue = 0;
    end
    o_src = bus.src_req_start; o_sink = bus.sink_req_start; o_es = bus.eng_start; o_ec = bus.eng_clear;
    o_ee = bus.eng_enable; o_ue = bus.ucode_enable; o_uc = bus.ucode_clear;
    o_done = done_o; o_err = err_o; o_busy = busy_o; o_state = state_o;
    chk("outputs", {o_src, o_sink, o_es, o_ec, o_ee, o_ue, o_uc, o_done, o_err, o_busy, o_state},
        {e_src, e_sink, e_es, e_ec, e_ee, e_ue, e_uc, e_done, e_err, 1'(m_state != 0), 3'(m_state)});
    if (prev_pulse) chk("done_err_spacing", {o_done, o_err}, 2'b00);
    prev_pulse = o_done | o_err;
    if (o_src != 0 || o_sink != 0) launches++;
    dones += int'(o_done); errs += int'(o_err); ue_pulses += int'(o_ue);
    @(posedge clk); #1;
    m_wd    = (stuck && nxt == m_state) ? ((m_wd < 15) ? m_wd + 1 : 15) : 0;
    m_state = nxt;
    if (launch) env_need_step = 1;
    if (e_ue) begin env_need_step = 0; env_iter++; end
    if (e_uc) begin env_iter = 0; env_need_step = 0; end
    for (int k = 0; k < N_SINK; k++) begin
      if (e_ec) env_cnt[k] = '0;
      else if (e_ee && cnt_auto && env_cnt[k] != '1) env_cnt[k] = env_cnt[k] + CNT_W'($urandom_range(1));
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_ni = 1'b0; #1;
    chk("rst_state", state_o, 0);
    chk("rst_req", {bus.src_req_start, bus.sink_req_start}, 0);
    chk("rst_eng_clear", bus.eng_clear, 1);
    @(posedge clk); #1;
    chk("rst_state_next", state_o, 0);
    chk("rst_clears_next", {bus.eng_clear, bus.ucode_clear, bus.eng_start}, 3'b110);
    @(negedge clk);
    rst_ni = 1'b1;
    m_state = 0; m_wd = 0; env_iter = 0; env_need_step = 0; prev_pulse = 0;
    for (int k = 0; k < N_SINK; k++) env_cnt[k] = '0;
  endtask

  task automatic run_job(input string tag, input int budget);
    int n = 0;
    while (m_state != 0 && n < budget) begin step(); n++; end
    chk({tag, "_back_idle"}, state_o, 0);
  endtask

  task automatic kick();
    start_i = 1'b1; step(); start_i = 1'b0;
  endtask

  initial begin
    int waits;
    rst_ni = 1'b0; clear_i = 1'b0; start_i = 1'b0;
    src_mask = '0; sink_mask = '0; cnt_limit = '0; tmo_limit = '0;
    for (int k = 0; k < N_SINK; k++) env_cnt[k] = '0;
    bus.src_ready_start = '0; bus.sink_ready_start = '0; bus.cnt_out = '0;
    bus.eng_ready = 1'b0; bus.ucode_valid = 1'b1; bus.ucode_done = 1'b0;
    @(negedge clk);
    apply_reset();
    step(); step();
    chk("idle_outputs", {o_ec, o_uc, o_busy, o_state}, 6'b110_000);

    // Single masked source, limits 8/4 on two sinks
    src_mask = 2'b01; sink_mask = 2'b11; cnt_limit = {8'd4, 8'd8};
    src_rdy_fix = 2'b01; sink_rdy_fix = 2'b11; env_tiles = 1; cnt_auto = 0;
    kick();
    step();
    chk("mask_src_req", o_src, 2'b01);
    chk("mask_sink_req", o_sink, 2'b11);
    step();
    chk("mask_in_compute", o_state, 2);
    chk("mask_req_one_cycle", {o_src, o_sink}, 0);
    env_cnt[0] = 8'd8; env_cnt[1] = 8'd3; step(); step();
    chk("limit_8_3_stays", o_state, 2);
    env_cnt[1] = 8'd4; step();
    chk("limit_8_4_cycle", o_state, 2);
    step();
    chk("limit_8_4_update", o_state, 3);
    run_job("limit", 50);

    // Limits compare unsigned; masked sink ignored
    src_mask = 2'b10; sink_mask = 2'b01; cnt_limit = {8'd4, 8'd100};
    src_rdy_fix = 2'b11; sink_rdy_fix = 2'b11;
    kick(); step(); step();
    chk("uns_compute", o_state, 2);
    env_cnt[0] = 8'd99; step(); step();
    chk("uns_below_limit", o_state, 2);
    env_cnt[0] = 8'd130; step(); step();
    chk("uns_above_limit", o_state, 3);
    run_job("uns", 50);

    // Reset mid-COMPUTE
    src_mask = 2'b11; sink_mask = 2'b01; cnt_limit = {8'd4, 8'd50};
    kick(); step(); step();
    chk("pre_reset_compute", o_state, 2);
    apply_reset();
    step();
    chk("post_reset_idle", {o_state, o_ec}, 4'b000_1);

    // Three uloop tiles
    clr_sb(); cnt_auto = 1; rdy_rand = 1; rdy_pct = 60; env_tiles = 3; tmo_limit = '0;
    cnt_limit = {8'd2, 8'd3};
    kick(); run_job("ucode3", 400);
    chk("ucode3_launches", launches, 3);
    chk("ucode3_steps", ue_pulses, 3);
    chk("ucode3_done_err", {dones[7:0], errs[7:0]}, {8'd1, 8'd0});

    // Stall watchdog out of WAIT
    clr_sb(); rdy_rand = 0; src_rdy_fix = 2'b11; sink_rdy_fix = 2'b00; tmo_limit = 4'd5;
    kick(); step();
    chk("wd_start_state", o_state, 1);
    waits = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (o_err) break;
      if (o_state == 4) waits++;
    end
    chk("wd_wait_cycles", waits, 5);
    chk("wd_err_with_done", {o_err, o_done, o_state}, {2'b11, 3'd4});
    step();
    chk("wd_back_idle", o_state, 0);

    // Soft clear from WAIT
    tmo_limit = '0;
    kick(); step(); step();
    chk("clr_in_wait", o_state, 4);
    clear_i = 1'b1; step(); clear_i = 1'b0; step();
    chk("clr_to_idle", o_state, 0);

    // Empty job
    clr_sb(); src_mask = '0; sink_mask = '0;
    kick(); step();
    chk("empty_terminate", {o_state, o_done}, {3'd5, 1'b1});
    chk("empty_no_launch", {o_src, o_sink, o_es}, 0);
    step();
    chk("empty_idle", {o_state, o_done}, 4'b000_0);

    // Randomized jobs
    cnt_auto = 1; rdy_rand = 1;
    for (int j = 0; j < 25; j++) begin
      int n;
      src_mask = N_SRC'($urandom); sink_mask = N_SINK'($urandom);
      cnt_limit = {8'($urandom_range(5, 1)), 8'($urandom_range(5, 1))};
      env_tiles = $urandom_range(3, 1);
      tmo_limit = ($urandom_range(3) == 0) ? 4'd0 : 4'($urandom_range(15, 4));
      rdy_pct = $urandom_range(90, 50);
      clr_sb();
      kick();
      n = 0;
      while (m_state != 0 && n < 600) begin
        start_i = ($urandom_range(9) == 0);
        step(); n++;
      end
      start_i = 1'b0;
      chk("rnd_back_idle", state_o, 0);
      chk("rnd_one_done", dones, 1);
      if (errs == 0) chk("rnd_launches", launches, (src_mask == 0 && sink_mask == 0) ? 0 : env_tiles);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time bound exceeded");
  end
endmodule
